// File: rtl/ldpc_enc_scheduler.sv
// Round-robin front end that time-shares one LDPC encoder between NUM_REQ block sources.
// One block in flight at a time: accept, start pulse, wait for done (with timeout), hand off downstream.
module ldpc_enc_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int MESSAGE_LEN    = 360,
    parameter int CODEWORD_LEN   = 672,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_W           = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*MESSAGE_LEN-1:0] req_data,
    output logic                           enc_start,
    output logic [MESSAGE_LEN-1:0]         enc_data_in,
    input  logic [CODEWORD_LEN-1:0]        enc_codeword,
    input  logic                           enc_done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CODEWORD_LEN-1:0]        out_codeword,
    output logic [ID_W-1:0]                out_id,
    output logic                           busy,
    output logic                           err_timeout,
    output logic [15:0]                    blk_count
);

    localparam int unsigned NREQ_U  = NUM_REQ;
    localparam int          TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t                    state_q;
    logic [ID_W-1:0]           ptr_q;
    logic [TO_W-1:0]           tmo_q;
    logic                      enc_start_q;
    logic [MESSAGE_LEN-1:0]    data_q;
    logic [CODEWORD_LEN-1:0]   cw_q;
    logic [ID_W-1:0]           id_q;
    logic                      out_valid_q;
    logic                      err_q;
    logic [15:0]               blk_q;

    logic                      grant_vld;
    logic [ID_W-1:0]           grant_idx;
    logic [MESSAGE_LEN-1:0]    req_msg [NUM_REQ];

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned    off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ_U) begin
            s = s - NREQ_U;
        end
        return ID_W'(s);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_msg[g] = req_data[g*MESSAGE_LEN +: MESSAGE_LEN];
    end

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            if (!grant_vld && req_valid[wrap_add(ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            tmo_q       <= '0;
            enc_start_q <= 1'b0;
            data_q      <= '0;
            cw_q        <= '0;
            id_q        <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            blk_q       <= '0;
        end else begin
            enc_start_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        data_q      <= req_msg[grant_idx];
                        id_q        <= grant_idx;
                        ptr_q       <= wrap_add(grant_idx, 1);
                        enc_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                // Counter equals the index of the current WAIT cycle; done beats expiry.
                S_WAIT: begin
                    if (enc_done) begin
                        cw_q        <= enc_codeword;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end else if (tmo_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        blk_q       <= blk_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign enc_start    = enc_start_q;
    assign enc_data_in  = data_q;
    assign out_valid    = out_valid_q;
    assign out_codeword = cw_q;
    assign out_id       = id_q;
    assign busy         = (state_q != S_IDLE);
    assign err_timeout  = err_q;
    assign blk_count    = blk_q;

endmodule
